// File: rtl/addsub_pipe_nbit_pkg.sv
// Shared constants for the pipelined adder-subtractor.
//   OP_ADD / OP_SUB : encodings of the add_n operation select
//   sat_max(w)      : largest signed w-bit value  (0111...1), w <= 64
//   sat_min(w)      : smallest signed w-bit value (1000...0), w <= 64
package addsub_pipe_nbit_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] sat_max(input int w);
        sat_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int w);
        sat_min = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// Plain n-bit ripple-carry adder used for one pipeline slice.
//   a, b  : operand slices
//   c_in  : carry into bit 0
//   s     : slice sum
//   c_out : carry out of bit n-1
module rca_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         c_in,
    output logic [n-1:0] s,
    output logic         c_out
);

    logic [n:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < n; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = c[n];

endmodule

// File: rtl/addsub_pipe_nbit.sv
// Pipelined signed/unsigned adder-subtractor resolving SEG bits per stage,
// L = n/SEG stages, valid/ready handshake with full back-pressure.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : input beat handshake
//   x, y, add_n, sat     : operands, 0=add 1=sub, signed saturation enable
//   out_valid / out_ready: result handshake
//   s, c_out, overflow   : result, MSB carry, signed overflow of raw sum
//   zero                 : s == 0 after saturation
// n must be a multiple of SEG and n <= 64.
module addsub_pipe_nbit
    import addsub_pipe_nbit_pkg::*;
#(
    parameter int n   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         add_n,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] s,
    output logic         c_out,
    output logic         overflow,
    output logic         zero
);

    localparam int L = n / SEG;
    localparam logic [n-1:0] S_MAX = n'(sat_max(n));
    localparam logic [n-1:0] S_MIN = n'(sat_min(n));

    // Whole pipe moves in lockstep; an empty or draining output frees it.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    genvar k;
    for (k = 1; k <= L; k++) begin : g_stg
        // Width of the inverted-y slices still unprocessed on entry to stage k.
        localparam int YW = n - (k - 1) * SEG;

        // xs carries partial sum in its low (k-1)*SEG bits and the untouched
        // x slices above, so x's MSB is still present at the final stage.
        logic [n-1:0]    xs_i;
        logic [YW-1:0]   yb_i;
        logic            c_i;
        logic            v_i;
        logic            sat_i;
        logic [SEG-1:0]  sl_s;
        logic            sl_co;
        logic [n-1:0]    xs_nx;

        if (k == 1) begin : g_src
            // Subtraction as x + ~y + 1: invert y once, carry-in = 1.
            assign xs_i  = x;
            assign yb_i  = y ^ {n{add_n == OP_SUB}};
            assign c_i   = (add_n == OP_SUB);
            assign v_i   = in_valid;
            assign sat_i = sat;
        end else begin : g_src
            assign xs_i  = g_stg[k-1].g_mid.xs_q;
            assign yb_i  = g_stg[k-1].g_mid.yr_q;
            assign c_i   = g_stg[k-1].g_mid.c_q;
            assign v_i   = g_stg[k-1].g_mid.v_q;
            assign sat_i = g_stg[k-1].g_mid.sat_q;
        end

        rca_nbit #(.n(SEG)) u_rca (
            .a    (xs_i[(k-1)*SEG +: SEG]),
            .b    (yb_i[SEG-1:0]),
            .c_in (c_i),
            .s    (sl_s),
            .c_out(sl_co)
        );

        always_comb begin
            xs_nx = xs_i;
            xs_nx[(k-1)*SEG +: SEG] = sl_s;
        end

        if (k < L) begin : g_mid
            logic [n-1:0]      xs_d, xs_q;
            logic [YW-SEG-1:0] yr_d, yr_q;
            logic              c_d, c_q;
            logic              v_d, v_q;
            logic              sat_d, sat_q;

            always_comb begin
                xs_d  = adv ? xs_nx          : xs_q;
                yr_d  = adv ? yb_i[YW-1:SEG] : yr_q;
                c_d   = adv ? sl_co          : c_q;
                v_d   = adv ? v_i            : v_q;
                sat_d = adv ? sat_i          : sat_q;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    xs_q  <= '0;
                    yr_q  <= '0;
                    c_q   <= 1'b0;
                    v_q   <= 1'b0;
                    sat_q <= 1'b0;
                end else begin
                    xs_q  <= xs_d;
                    yr_q  <= yr_d;
                    c_q   <= c_d;
                    v_q   <= v_d;
                    sat_q <= sat_d;
                end
            end
        end else begin : g_fin
            logic         xa, yb, r, ovf_raw;
            logic [n-1:0] s_fin;
            logic [n-1:0] s_d, s_q;
            logic         c_d, c_q;
            logic         ovf_d, ovf_q;
            logic         z_d, z_q;
            logic         v_d, v_q;

            always_comb begin
                xa      = xs_i[n-1];
                yb      = yb_i[SEG-1];
                r       = sl_s[SEG-1];
                // Operands of equal sign producing a result of the other sign.
                ovf_raw = (xa & yb & ~r) | (~xa & ~yb & r);
                // On overflow the true result lies beyond the limit on x's side.
                s_fin   = (sat_i & ovf_raw) ? (xa ? S_MIN : S_MAX) : xs_nx;

                s_d     = adv ? s_fin           : s_q;
                c_d     = adv ? sl_co           : c_q;
                ovf_d   = adv ? ovf_raw         : ovf_q;
                z_d     = adv ? (s_fin == '0)   : z_q;
                v_d     = adv ? v_i             : v_q;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s_q   <= '0;
                    c_q   <= 1'b0;
                    ovf_q <= 1'b0;
                    z_q   <= 1'b0;
                    v_q   <= 1'b0;
                end else begin
                    s_q   <= s_d;
                    c_q   <= c_d;
                    ovf_q <= ovf_d;
                    z_q   <= z_d;
                    v_q   <= v_d;
                end
            end
        end
    end

    assign out_valid = g_stg[L].g_fin.v_q;
    assign s         = g_stg[L].g_fin.s_q;
    assign c_out     = g_stg[L].g_fin.c_q;
    assign overflow  = g_stg[L].g_fin.ovf_q;
    assign zero      = g_stg[L].g_fin.z_q;

endmodule

// File: tb/tb_addsub_pipe_nbit.sv
// Self-checking bench for addsub_pipe_nbit (n=16, SEG=4, L=4).
module tb_addsub_pipe_nbit;
    import addsub_pipe_nbit_pkg::*;

    localparam int N   = 16;
    localparam int SEG = 4;
    localparam int L   = N / SEG;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;
    logic         add_n = 1'b0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] s;
    logic         c_out;
    logic         overflow;
    logic         zero;

    addsub_pipe_nbit #(.n(N), .SEG(SEG)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .add_n(add_n), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0] s;
        logic        c, o, z;
        int          age;   // accepting edges seen; L means sitting at the output
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference: integer arithmetic straight from the operation's definition.
    function automatic exp_t ref_op(input logic [15:0] a, input logic [15:0] b,
                                    input logic sub, input logic st);
        exp_t e;
        int sa, sb, sr, ua, ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        sr = sub ? sa - sb : sa + sb;
        e.o = (sr > 32767) || (sr < -32768);
        e.c = sub ? (ua >= ub) : ((ua + ub) > 65535);
        if (st && e.o) e.s = (sr > 0) ? 16'h7FFF : 16'h8000;
        else           e.s = sr[15:0];
        e.z   = (e.s == 16'h0000);
        e.age = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] sv, input logic cv,
                                input logic ov, input logic zv);
        exp_t e;
        e.s = sv; e.c = cv; e.o = ov; e.z = zv; e.age = 0;
        return e;
    endfunction

    // One clock cycle: drive at negedge, check the settled outputs, then
    // update the scoreboard for what the coming rising edge will do.
    task automatic cyc(input logic iv, input logic [15:0] xx, input logic [15:0] yy,
                       input logic an, input logic st, input logic od,
                       input logic lit_en, input exp_t lit, output logic acc);
        logic exp_ov, adv_m;
        exp_t e, d;
        @(negedge clk);
        in_valid = iv; x = xx; y = yy; add_n = an; sat = st; out_ready = od;
        #1;
        exp_ov = (q.size() > 0) && (q[0].age >= L);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, !exp_ov || od);
        if (exp_ov) begin
            chk("s", s, q[0].s);
            chk("c_out", c_out, q[0].c);
            chk("overflow", overflow, q[0].o);
            chk("zero", zero, q[0].z);
        end
        adv_m = !exp_ov || od;
        acc   = iv && adv_m;
        if (adv_m) begin
            if (exp_ov) d = q.pop_front();
            foreach (q[i]) q[i].age++;
            if (iv) begin
                e = lit_en ? lit : ref_op(xx, yy, an, st);
                e.age = 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int ncyc);
        logic a;
        for (int i = 0; i < ncyc; i++) cyc(1'b0, 16'h0, 16'h0, OP_ADD, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0), a);
    endtask

    initial begin
        logic a;
        int   nxt, lat;
        logic [15:0] rx, ry;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_s", s, 16'h0);
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_zero", zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors, back to back, with literal expectations
        cyc(1, 16'h1234, 16'h0FED, OP_ADD, 0, 1, 1, mk(16'h2221, 0, 0, 0), a);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (out_valid && lat == 0) lat = i;
        end
        chk("first_latency", lat, L);
        cyc(1, 16'h7FFF, 16'h0001, OP_ADD, 0, 1, 1, mk(16'h8000, 0, 1, 0), a);
        cyc(1, 16'h7FFF, 16'h0001, OP_ADD, 1, 1, 1, mk(16'h7FFF, 0, 1, 0), a);
        cyc(1, 16'h8000, 16'h0001, OP_SUB, 1, 1, 1, mk(16'h8000, 1, 1, 0), a);
        cyc(1, 16'hABCD, 16'hABCD, OP_SUB, 0, 1, 1, mk(16'h0000, 1, 0, 1), a);
        cyc(1, 16'h1357, 16'h0000, OP_SUB, 0, 1, 1, mk(16'h1357, 1, 0, 0), a);
        cyc(1, 16'hFFFF, 16'h0001, OP_ADD, 0, 1, 1, mk(16'h0000, 1, 0, 1), a);
        idle(L + 2);

        // Back-pressure: six beats, consumer stalls on cycles 5-7
        nxt = 1;
        for (int c = 1; c <= 16; c++) begin
            logic od;
            od = !(c >= 5 && c <= 7);
            if (nxt <= 6)
                cyc(1, 16'(nxt), 16'(nxt), OP_ADD, 0, od, 1, mk(16'(2 * nxt), 0, 0, 0), a);
            else
                cyc(0, 16'h0, 16'h0, OP_ADD, 0, od, 0, mk(0, 0, 0, 0), a);
            if (c >= 5 && c <= 7) chk("bp_in_ready_low", in_ready, 1'b0);
            if (a) nxt++;
        end
        chk("bp_all_accepted", nxt, 7);
        chk("bp_all_drained", q.size(), 0);

        // Alternating bubbles
        for (int i = 0; i < 8; i++)
            cyc(i[0] == 1'b0, 16'(100 + i), 16'(3 * i), OP_SUB, 0, 1, 0, mk(0, 0, 0, 0), a);
        idle(L + 1);

        // Async reset with beats in flight, one of them at the output
        for (int i = 0; i < 4; i++)
            cyc(1, 16'(16'h0101 * (i + 1)), 16'h0011, OP_ADD, 0, 0, 0, mk(0, 0, 0, 0), a);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_s", s, 16'h0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 16'h4000, 16'h4000, OP_ADD, 1, 1, 1, mk(16'h7FFF, 0, 1, 0), a);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (out_valid && lat == 0) lat = i;
        end
        chk("post_rst_latency", lat, L);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rx = 16'($urandom());
            ry = ($urandom_range(0, 7) == 0) ? rx : 16'($urandom());
            cyc($urandom_range(0, 3) != 0, rx, ry, 1'($urandom()), 1'($urandom()),
                $urandom_range(0, 3) != 0, 0, mk(0, 0, 0, 0), a);
        end
        idle(L + 2);
        chk("final_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
